// File: rtl/serial_byte_ctrl.sv
// serial_byte_ctrl: serial-to-byte assembler with slot demux select; SERIAL_BYTE_CTRL_TIMEOUT_EN adds an inter-bit timeout with outErr.
module serial_byte_ctrl #(
    parameter int LSB_FIRST = 1
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       inSync,
    input  logic       inValid,
    input  logic       inData,
    output logic       inReady,
    output logic [2:0] outSel,
    output logic       outValid,
    input  logic       outReady,
    output logic [7:0] outByte
`ifdef SERIAL_BYTE_CTRL_TIMEOUT_EN
    ,
    output logic       outErr
`endif
);
    typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;
    state_t     state;
    logic [2:0] slotCnt;
    logic       inXfer;
    logic       outXfer;
`ifdef SERIAL_BYTE_CTRL_TIMEOUT_EN
    logic [3:0] idleCnt;
`endif
    function automatic logic [2:0] slotSel(input logic [2:0] c);
        return (LSB_FIRST != 0) ? c : ~c;
    endfunction
    // inSync outranks outReady in FULL so a sync never admits a bit into the next byte
    assign inReady = (state == FULL) ? (outReady & ~inSync) : ~inSync;
    assign inXfer  = inValid & inReady;
    assign outXfer = outValid & outReady;
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state    <= IDLE;
            slotCnt  <= 3'd0;
            outSel   <= slotSel(3'd0);
            outByte  <= 8'h00;
            outValid <= 1'b0;
`ifdef SERIAL_BYTE_CTRL_TIMEOUT_EN
            idleCnt  <= 4'd0;
            outErr   <= 1'b0;
`endif
        end else begin
`ifdef SERIAL_BYTE_CTRL_TIMEOUT_EN
            idleCnt <= 4'd0;
            outErr  <= 1'b0;
`endif
            if (inSync && state != FULL) begin
                state   <= IDLE;
                slotCnt <= 3'd0;
                outSel  <= slotSel(3'd0);
                outByte <= 8'h00;
            end else if (inXfer) begin
                // a bit accepted in FULL starts a fresh byte in the cycle the old one leaves
                outByte  <= ((state == FULL) ? 8'h00 : outByte) | ({7'b0, inData} << outSel);
                slotCnt  <= slotCnt + 3'd1;
                outSel   <= slotSel(slotCnt + 3'd1);
                state    <= (slotCnt == 3'd7) ? FULL : FILL;
                outValid <= (slotCnt == 3'd7);
            end else if (outXfer) begin
                state    <= IDLE;
                outByte  <= 8'h00;
                outValid <= 1'b0;
            end
`ifdef SERIAL_BYTE_CTRL_TIMEOUT_EN
            else if (state == FILL) begin
                if (idleCnt == 4'd14) begin
                    state   <= IDLE;
                    slotCnt <= 3'd0;
                    outSel  <= slotSel(3'd0);
                    outByte <= 8'h00;
                    outErr  <= 1'b1;
                end else begin
                    idleCnt <= idleCnt + 4'd1;
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_serial_byte_ctrl.sv
// tb_serial_byte_ctrl: vector table plus directed corner sequences for both bit orders.
module tb_serial_byte_ctrl;
    logic       clk = 1'b0, resetb = 1'b0, inSync = 1'b0, inValid = 1'b0, inData = 1'b0, outReady = 1'b1;
    logic       inReady, outValid, inReady0, outValid0;
    logic [2:0] outSel, outSel0;
    logic [7:0] outByte, outByte0;
`ifdef SERIAL_BYTE_CTRL_TIMEOUT_EN
    logic       outErr, outErr0;
`endif
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    serial_byte_ctrl #(.LSB_FIRST(1)) dut (
        .clk(clk), .resetb(resetb), .inSync(inSync), .inValid(inValid), .inData(inData),
        .inReady(inReady), .outSel(outSel), .outValid(outValid), .outReady(outReady), .outByte(outByte)
`ifdef SERIAL_BYTE_CTRL_TIMEOUT_EN
        , .outErr(outErr)
`endif
    );

    serial_byte_ctrl #(.LSB_FIRST(0)) dut0 (
        .clk(clk), .resetb(resetb), .inSync(inSync), .inValid(inValid), .inData(inData),
        .inReady(inReady0), .outSel(outSel0), .outValid(outValid0), .outReady(outReady), .outByte(outByte0)
`ifdef SERIAL_BYTE_CTRL_TIMEOUT_EN
        , .outErr(outErr0)
`endif
    );

    typedef struct {
        logic       sync, valid, data, ordy;
        logic       expReady, expValid;
        logic [7:0] expByte, expByte0;
        logic [2:0] expSel;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sendBit(input logic d);
        inValid = 1'b1;
        inData  = d;
        tick();
        inValid = 1'b0;
    endtask

    task automatic checkIdle(input string name);
        check({name, " valid"}, outValid, 1'b0);
        check({name, " byte"}, outByte, 8'h00);
        check({name, " sel"}, outSel, 3'd0);
        check({name, " sel0"}, outSel0, 3'd7);
        check({name, " byte0"}, outByte0, 8'h00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] pat;
        int errCnt, errAt;
        // sync valid data ordy | ready valid byte byte0 sel
        vecs.push_back('{0,1,1,1, 1,0,8'h01,8'h80,3'd1});
        vecs.push_back('{0,1,0,1, 1,0,8'h01,8'h80,3'd2});
        vecs.push_back('{0,1,1,1, 1,0,8'h05,8'hA0,3'd3});
        vecs.push_back('{0,1,1,1, 1,0,8'h0D,8'hB0,3'd4});
        vecs.push_back('{0,1,0,1, 1,0,8'h0D,8'hB0,3'd5});
        vecs.push_back('{0,1,0,1, 1,0,8'h0D,8'hB0,3'd6});
        vecs.push_back('{0,1,1,1, 1,0,8'h4D,8'hB2,3'd7});
        vecs.push_back('{0,1,0,1, 1,1,8'h4D,8'hB2,3'd0});
        for (int i = 0; i < 5; i++)
            vecs.push_back('{0,1,1,0, 0,1,8'h4D,8'hB2,3'd0});
        vecs.push_back('{0,1,1,1, 1,0,8'h01,8'h80,3'd1});
        vecs.push_back('{0,1,1,1, 1,0,8'h03,8'hC0,3'd2});
        vecs.push_back('{0,1,1,1, 1,0,8'h07,8'hE0,3'd3});
        vecs.push_back('{1,1,1,1, 0,0,8'h00,8'h00,3'd0});
        vecs.push_back('{0,1,1,1, 1,0,8'h01,8'h80,3'd1});
        vecs.push_back('{0,1,1,1, 1,0,8'h03,8'hC0,3'd2});
        vecs.push_back('{0,1,1,1, 1,0,8'h07,8'hE0,3'd3});
        vecs.push_back('{0,1,1,1, 1,0,8'h0F,8'hF0,3'd4});
        vecs.push_back('{0,1,1,1, 1,0,8'h1F,8'hF8,3'd5});
        vecs.push_back('{0,1,1,1, 1,0,8'h3F,8'hFC,3'd6});
        vecs.push_back('{0,1,1,1, 1,0,8'h7F,8'hFE,3'd7});
        vecs.push_back('{0,1,1,1, 1,1,8'hFF,8'hFF,3'd0});
        vecs.push_back('{0,0,0,1, 1,0,8'h00,8'h00,3'd0});

        tick();
        tick();
        checkIdle("reset");
        check("reset inReady", inReady, 1'b1);
        resetb = 1'b1;

        foreach (vecs[i]) begin
            inSync = vecs[i].sync; inValid = vecs[i].valid; inData = vecs[i].data; outReady = vecs[i].ordy;
            #1;
            check($sformatf("vec%0d inReady", i), inReady, vecs[i].expReady);
            check($sformatf("vec%0d inReady0", i), inReady0, vecs[i].expReady);
            tick();
            check($sformatf("vec%0d outValid", i), outValid, vecs[i].expValid);
            check($sformatf("vec%0d outByte", i), outByte, vecs[i].expByte);
            check($sformatf("vec%0d outSel", i), outSel, vecs[i].expSel);
            check($sformatf("vec%0d outByte0", i), outByte0, vecs[i].expByte0);
            check($sformatf("vec%0d outSel0", i), outSel0, 3'd7 - vecs[i].expSel);
        end
        inSync = 1'b0; inValid = 1'b0; outReady = 1'b1;

        // sync while FULL keeps the byte and blocks input
        pat = 8'h01;
        for (int i = 0; i < 8; i++) sendBit(pat[i]);
        check("full01 valid", outValid, 1'b1);
        check("full01 byte", outByte, 8'h01);
        check("full01 byte0", outByte0, 8'h80);
        outReady = 1'b0; inSync = 1'b1; inValid = 1'b1; inData = 1'b1;
        #1;
        check("syncFull inReady", inReady, 1'b0);
        tick();
        check("syncFull held valid", outValid, 1'b1);
        check("syncFull held byte", outByte, 8'h01);
        outReady = 1'b1;
        #1;
        check("syncFull drain inReady", inReady, 1'b0);
        tick();
        inSync = 1'b0; inValid = 1'b0;
        checkIdle("syncFull drained");

        // async reset mid-byte
        for (int i = 0; i < 5; i++) sendBit(1'b1);
        check("pre-reset byte", outByte, 8'h1F);
        #2 resetb = 1'b0;
        #1;
        checkIdle("midReset");
        tick();
        resetb = 1'b1;
        pat = 8'h4D;
        for (int i = 0; i < 8; i++) sendBit(pat[i]);
        check("postReset valid", outValid, 1'b1);
        check("postReset byte", outByte, 8'h4D);
        check("postReset byte0", outByte0, 8'hB2);
        tick();
        checkIdle("postReset drained");

`ifdef SERIAL_BYTE_CTRL_TIMEOUT_EN
        sendBit(1'b1);
        sendBit(1'b1);
        errCnt = 0; errAt = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (outErr) begin errCnt++; errAt = i; end
            if (i == 15) checkIdle("timeout abort");
        end
        check("timeout outErr pulses", errCnt[7:0], 8'd1);
        check("timeout outErr cycle", errAt[7:0], 8'd15);
        pat = 8'h4D;
        for (int i = 0; i < 8; i++) sendBit(pat[i]);
        check("postTimeout valid", outValid, 1'b1);
        check("postTimeout byte", outByte, 8'h4D);
        check("postTimeout byte0", outByte0, 8'hB2);
`else
        errCnt = 0; errAt = 0;
        sendBit(1'b1);
        sendBit(1'b1);
        for (int i = 0; i < 100; i++) tick();
        check("wait valid", outValid, 1'b0);
        check("wait byte", outByte, 8'h03);
        check("wait sel", outSel, 3'd2);
        pat = 8'hF3;
        for (int i = 2; i < 8; i++) sendBit(pat[i]);
        check("afterWait valid", outValid, 1'b1);
        check("afterWait byte", outByte, 8'hF3);
        check("afterWait byte0", outByte0, 8'hCF);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
